// File: rtl/mario_anim_ctrl.sv
// Player sprite animation sequencer: picks pose and facing once per video frame and
// produces a registered, mirror-corrected sprite ROM address for every pixel.
module mario_anim_ctrl #(
    parameter int FRAMES_PER_STEP = 6,
    parameter int SPR_W           = 26,
    parameter int SPR_H           = 32
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic       mario_alive,
    input  logic       mario_in_air,
    input  logic [9:0] x_motion,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic [9:0] mario_x,
    input  logic [9:0] mario_y,
    input  logic [9:0] process,
    output logic [2:0] sprite_sel,
    output logic       face_left,
    output logic [9:0] rom_addr,
    output logic       in_sprite,
    output logic       anim_tick
);

    typedef enum logic [2:0] {
        ST_STAND = 3'd0,
        ST_WALK1 = 3'd1,
        ST_WALK2 = 3'd2,
        ST_WALK3 = 3'd3,
        ST_JUMP  = 3'd4,
        ST_DEAD  = 3'd5
    } pose_t;

    localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(FRAMES_PER_STEP - 1);

    // [0],[1] form the synchronizer; [2] is the previous synchronized value for edge detect
    logic [2:0]       sync_q, sync_d;
    logic             anim_tick_q, anim_tick_d;
    pose_t            pose_q, pose_d;
    logic             face_left_q, face_left_d;
    logic [CNT_W-1:0] step_q, step_d;
    logic [9:0]       rom_addr_q, rom_addr_d;
    logic             in_sprite_q, in_sprite_d;
    logic [9:0]       col, row, col_m;

    always_comb begin
        sync_d      = {sync_q[1:0], frame_clk};
        anim_tick_d = sync_q[2] & ~sync_q[1];
    end

    always_comb begin
        pose_d      = pose_q;
        step_d      = step_q;
        face_left_d = face_left_q;
        if (anim_tick_q) begin
            if (pose_q == ST_DEAD || !mario_alive) begin
                pose_d = ST_DEAD;
            end else begin
                if (x_motion[9])
                    face_left_d = 1'b1;
                else if (x_motion != 10'd0)
                    face_left_d = 1'b0;

                if (mario_in_air) begin
                    pose_d = ST_JUMP;
                    step_d = '0;
                end else if (x_motion == 10'd0) begin
                    pose_d = ST_STAND;
                    step_d = '0;
                end else begin
                    case (pose_q)
                        ST_WALK1, ST_WALK2, ST_WALK3: begin
                            if (step_q == STEP_LAST) begin
                                step_d = '0;
                                case (pose_q)
                                    ST_WALK1: pose_d = ST_WALK2;
                                    ST_WALK2: pose_d = ST_WALK3;
                                    default:  pose_d = ST_WALK1;
                                endcase
                            end else begin
                                step_d = step_q + 1'b1;
                            end
                        end
                        default: begin
                            pose_d = ST_WALK1;
                            step_d = '0;
                        end
                    endcase
                end
            end
        end
    end

    // Wrap-around makes pixels left of / above the sprite look huge, so one unsigned compare suffices
    always_comb begin
        col         = DrawX - mario_x + process;
        row         = DrawY - mario_y;
        col_m       = (face_left_q && pose_q != ST_DEAD) ? (10'(SPR_W - 1) - col) : col;
        in_sprite_d = (col < 10'(SPR_W)) && (row < 10'(SPR_H));
        rom_addr_d  = in_sprite_d ? (row * 10'(SPR_W) + col_m) : 10'd0;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            sync_q      <= 3'b111;
            anim_tick_q <= 1'b0;
            pose_q      <= ST_STAND;
            face_left_q <= 1'b0;
            step_q      <= '0;
            rom_addr_q  <= 10'd0;
            in_sprite_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            anim_tick_q <= anim_tick_d;
            pose_q      <= pose_d;
            face_left_q <= face_left_d;
            step_q      <= step_d;
            rom_addr_q  <= rom_addr_d;
            in_sprite_q <= in_sprite_d;
        end
    end

    assign sprite_sel = pose_q;
    assign face_left  = face_left_q;
    assign rom_addr   = rom_addr_q;
    assign in_sprite  = in_sprite_q;
    assign anim_tick  = anim_tick_q;

endmodule

// File: tb/tb_mario_anim_ctrl.sv
// Directed bench for mario_anim_ctrl with two frames per walk image.
module tb_mario_anim_ctrl;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       frame_clk;
    logic       mario_alive;
    logic       mario_in_air;
    logic [9:0] x_motion;
    logic [9:0] DrawX, DrawY, mario_x, mario_y, process;
    logic [2:0] sprite_sel;
    logic       face_left;
    logic [9:0] rom_addr;
    logic       in_sprite;
    logic       anim_tick;

    int n_assert = 0;
    int n_fail   = 0;

    mario_anim_ctrl #(.FRAMES_PER_STEP(2), .SPR_W(26), .SPR_H(32)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
        .mario_alive(mario_alive), .mario_in_air(mario_in_air), .x_motion(x_motion),
        .DrawX(DrawX), .DrawY(DrawY), .mario_x(mario_x), .mario_y(mario_y),
        .process(process), .sprite_sel(sprite_sel), .face_left(face_left),
        .rom_addr(rom_addr), .in_sprite(in_sprite), .anim_tick(anim_tick)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // frame_clk falls before edge n; tick must be high only after edge n+2, new pose after n+3
    task automatic frame(input string tag, input logic [2:0] exp_sel, input logic exp_face);
        @(negedge Clk) frame_clk = 1'b0;
        @(negedge Clk) check({tag, " tick n"}, 32'(anim_tick), 32'd0);
        @(negedge Clk) check({tag, " tick n+1"}, 32'(anim_tick), 32'd0);
        @(negedge Clk) check({tag, " tick n+2"}, 32'(anim_tick), 32'd1);
        frame_clk = 1'b1;
        @(negedge Clk);
        check({tag, " tick n+3"}, 32'(anim_tick), 32'd0);
        check({tag, " sel"}, 32'(sprite_sel), 32'(exp_sel));
        check({tag, " face"}, 32'(face_left), 32'(exp_face));
        $display("frame %s: sprite_sel=%0d face_left=%0d", tag, sprite_sel, face_left);
        repeat (3) @(negedge Clk);
    endtask

    task automatic pix(input string tag, input logic [9:0] dx, input logic [9:0] dy,
                       input logic exp_in, input logic [9:0] exp_addr);
        @(negedge Clk);
        DrawX = dx;
        DrawY = dy;
        @(negedge Clk);
        check({tag, " in"}, 32'(in_sprite), 32'(exp_in));
        check({tag, " addr"}, 32'(rom_addr), 32'(exp_addr));
        $display("pixel %s: (%0d,%0d) in_sprite=%0d rom_addr=%0d", tag, dx, dy, in_sprite, rom_addr);
    endtask

    initial begin : stim
        logic seen_tick;
        Reset_n      = 1'b0;
        frame_clk    = 1'b1;
        mario_alive  = 1'b1;
        mario_in_air = 1'b0;
        x_motion     = 10'd0;
        DrawX        = 10'd0;
        DrawY        = 10'd0;
        mario_x      = 10'd100;
        mario_y      = 10'd200;
        process      = 10'd0;

        seen_tick = 1'b0;
        repeat (100) begin
            @(negedge Clk);
            seen_tick = seen_tick | anim_tick;
        end
        check("reset sel", 32'(sprite_sel), 32'd0);
        check("reset face", 32'(face_left), 32'd0);
        check("reset addr", 32'(rom_addr), 32'd0);
        check("reset in", 32'(in_sprite), 32'd0);
        Reset_n = 1'b1;
        repeat (10) begin
            @(negedge Clk);
            seen_tick = seen_tick | anim_tick;
        end
        check("no tick at release", 32'(seen_tick), 32'd0);

        pix("topleft", 10'd100, 10'd200, 1'b1, 10'd0);
        pix("botright", 10'd125, 10'd231, 1'b1, 10'd831);
        pix("right of box", 10'd126, 10'd200, 1'b0, 10'd0);
        pix("left of box", 10'd99, 10'd200, 1'b0, 10'd0);
        pix("below box", 10'd100, 10'd232, 1'b0, 10'd0);

        @(negedge Clk);
        process = 10'd30;
        DrawX   = 10'd70;
        DrawY   = 10'd201;
        #1;
        check("scroll latency old", 32'(rom_addr), 32'd0);
        @(negedge Clk);
        check("scroll in", 32'(in_sprite), 32'd1);
        check("scroll addr", 32'(rom_addr), 32'd26);
        $display("pixel scroll: in_sprite=%0d rom_addr=%0d", in_sprite, rom_addr);
        process = 10'd0;

        x_motion = 10'd1;
        frame("walk1", 3'd1, 1'b0);
        frame("walk2", 3'd1, 1'b0);
        frame("walk3", 3'd2, 1'b0);
        frame("walk4", 3'd2, 1'b0);
        frame("walk5", 3'd3, 1'b0);
        frame("walk6", 3'd3, 1'b0);
        frame("walk7", 3'd1, 1'b0);
        x_motion = 10'h3FF;
        frame("reverse", 3'd1, 1'b1);
        x_motion = 10'd0;
        frame("stop", 3'd0, 1'b1);

        pix("mirror topleft", 10'd100, 10'd200, 1'b1, 10'd25);
        pix("mirror botright", 10'd125, 10'd231, 1'b1, 10'd806);

        mario_in_air = 1'b1;
        x_motion     = 10'd2;
        frame("jump", 3'd4, 1'b0);
        mario_in_air = 1'b0;
        frame("land", 3'd1, 1'b0);
        frame("land hold", 3'd1, 1'b0);
        frame("land adv", 3'd2, 1'b0);
        mario_alive  = 1'b0;
        mario_in_air = 1'b1;
        x_motion     = 10'h3FF;
        frame("die", 3'd4 + 3'd1, 1'b0);
        mario_alive  = 1'b1;
        mario_in_air = 1'b0;
        frame("dead sticky", 3'd5, 1'b0);
        pix("dead unmirrored", 10'd100, 10'd200, 1'b1, 10'd0);

        @(negedge Clk) Reset_n = 1'b0;
        @(negedge Clk);
        check("reset from dead sel", 32'(sprite_sel), 32'd0);
        check("reset from dead addr", 32'(rom_addr), 32'd0);
        Reset_n = 1'b1;
        x_motion = 10'h3FF;
        frame("post reset walk", 3'd1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
